receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/uart_pkg.sv | 17 +
 rtl/receiver_sync_2ff.sv | 34 +++
 rtl/receiver.sv | 159 +++++++++++++++
 tb/tb_receiver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing at 115200 baud and the receiver state encoding.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int CLOCK_PER_BIT      = 217;
  localparam int HALF_CLOCK_PER_BIT = 108;
  localparam int CNT_W              = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/receiver_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input, with a configurable reset value.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // Next value of each stage.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// UART 8N1 receiver: samples each bit at its mid-point, pulses valid on a good frame
// and frame_error on a low stop bit, then waits in BREAK until the line returns high.
module receiver
  import uart_pkg::*;
#(
  parameter int clock_per_bit      = CLOCK_PER_BIT,
  parameter int half_clock_per_bit = HALF_CLOCK_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_error
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clock_per_bit - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_clock_per_bit - 1);

  logic             rx_s;
  logic             fall_s;
  uart_state_e      state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [2:0]       idx_d, idx_q;
  logic [7:0]       shift_d, shift_q;
  logic [7:0]       data_d, data_q;
  logic             valid_d, valid_q;
  logic             ferr_d, ferr_q;
  logic             busy_d, busy_q;
  logic             prev_d, prev_q;
  logic [1:0]       settle_d, settle_q;

  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (in),
    .q    (rx_s)
  );

  // prev_q only follows the line once the synchronizer holds real samples, so the
  // forced-high reset value cannot fake a falling edge when the line is low at release.
  assign fall_s = prev_q & ~rx_s;

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    prev_d   = (settle_q == 2'd2) ? rx_s : 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = {CNT_W{1'b0}};
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = 3'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      prev_q   <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: one full-rate instance for the scenario tests and a
// fast-baud instance fed by a bench-side transmitter for the 256-byte loopback sweep.
module tb_receiver;

  localparam int C     = 217;
  localparam int H     = 108;
  localparam int LB_C  = 16;
  localparam int LB_H  = 8;
  localparam int EXP_LAT = 2 + H + 9 * C + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_line = 1'b1;
  logic [7:0] data;
  logic       valid, busy, frame_error;
  logic       lb_line = 1'b1;
  logic [7:0] lb_data;
  logic       lb_valid, lb_busy, lb_frame_error;

  int cmp_cnt = 0;
  int mism_cnt = 0;
  int ferr_cnt = 0;
  int lb_ferr_cnt = 0;
  int overlap_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] lb_q[$];

  receiver #(.clock_per_bit(C), .half_clock_per_bit(H)) u_dut (
    .clock(clock), .reset(reset), .in(rx_line),
    .data(data), .valid(valid), .busy(busy), .frame_error(frame_error)
  );

  receiver #(.clock_per_bit(LB_C), .half_clock_per_bit(LB_H)) u_lb (
    .clock(clock), .reset(reset), .in(lb_line),
    .data(lb_data), .valid(lb_valid), .busy(lb_busy), .frame_error(lb_frame_error)
  );

  always #5 clock = ~clock;

  // Pulse monitor: every valid cycle records a byte, so a stretched pulse shows up as an extra entry.
  always @(negedge clock) begin
    if (valid) got_q.push_back(data);
    if (frame_error) ferr_cnt++;
    if (lb_valid) lb_q.push_back(lb_data);
    if (lb_frame_error) lb_ferr_cnt++;
    if ((valid && frame_error) || (lb_valid && lb_frame_error)) overlap_cnt++;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb, input bit lb);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (lb) lb_line = bits[i];
      else    rx_line = bits[i];
      repeat (cpb) @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    cmp_cnt++; if (data !== 8'h00) begin mism_cnt++; $display("FAIL reset_data: got %h want 00", data); end
    cmp_cnt++; if (valid !== 1'b0) begin mism_cnt++; $display("FAIL reset_valid: got %b want 0", valid); end
    cmp_cnt++; if (busy !== 1'b0) begin mism_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    cmp_cnt++; if (frame_error !== 1'b0) begin mism_cnt++; $display("FAIL reset_ferr: got %b want 0", frame_error); end
    reset = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_single;
    int lat;
    int base;
    logic busy_mid;
    base = got_q.size();
    lat = 0;
    busy_mid = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, C, 1'b0);
      begin
        while (valid !== 1'b1 && lat < 5000) begin
          @(negedge clock);
          lat++;
          if (lat == 1000) busy_mid = busy;
        end
      end
    join
    repeat (5) @(negedge clock);
    cmp_cnt++; if (lat !== EXP_LAT) begin mism_cnt++; $display("FAIL single_latency: got %0d want %0d", lat, EXP_LAT); end
    cmp_cnt++; if (busy_mid !== 1'b1) begin mism_cnt++; $display("FAIL single_busy_mid: got %b want 1", busy_mid); end
    cmp_cnt++; if (got_q.size() !== base + 1) begin mism_cnt++; $display("FAIL single_count: got %0d want %0d", got_q.size(), base + 1); end
    cmp_cnt++; if (got_q[base] !== 8'hA5) begin mism_cnt++; $display("FAIL single_pulse_data: got %h want a5", got_q[base]); end
    cmp_cnt++; if (data !== 8'hA5) begin mism_cnt++; $display("FAIL single_data_hold: got %h want a5", data); end
    cmp_cnt++; if (ferr_cnt !== 0) begin mism_cnt++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt); end
    cmp_cnt++; if (busy !== 1'b0) begin mism_cnt++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3];
    int base;
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    base = got_q.size();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, C, 1'b0);
    repeat (20) @(negedge clock);
    cmp_cnt++; if (got_q.size() !== base + 3) begin mism_cnt++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), base + 3); end
    for (int i = 0; i < 3; i++) begin
      cmp_cnt++; if (got_q[base + i] !== exp[i]) begin mism_cnt++; $display("FAIL b2b_data%0d: got %h want %h", i, got_q[base + i], exp[i]); end
    end
    cmp_cnt++; if (ferr_cnt !== 0) begin mism_cnt++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_glitch;
    int base;
    base = got_q.size();
    rx_line = 1'b0;
    repeat (50) @(negedge clock);
    rx_line = 1'b1;
    repeat (300) @(negedge clock);
    cmp_cnt++; if (got_q.size() !== base) begin mism_cnt++; $display("FAIL glitch_no_valid: got %0d want %0d", got_q.size(), base); end
    cmp_cnt++; if (ferr_cnt !== 0) begin mism_cnt++; $display("FAIL glitch_no_ferr: got %0d want 0", ferr_cnt); end
    cmp_cnt++; if (busy !== 1'b0) begin mism_cnt++; $display("FAIL glitch_busy: got %b want 0", busy); end
    send_frame(8'h5A, 1'b1, C, 1'b0);
    repeat (5) @(negedge clock);
    cmp_cnt++; if (got_q.size() !== base + 1) begin mism_cnt++; $display("FAIL glitch_next_count: got %0d want %0d", got_q.size(), base + 1); end
    cmp_cnt++; if (data !== 8'h5A) begin mism_cnt++; $display("FAIL glitch_next_data: got %h want 5a", data); end
  endtask

  task automatic test_frame_error;
    int base;
    base = got_q.size();
    send_frame(8'h81, 1'b0, C, 1'b0);
    repeat (1000) @(negedge clock);
    cmp_cnt++; if (ferr_cnt !== 1) begin mism_cnt++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt); end
    cmp_cnt++; if (got_q.size() !== base) begin mism_cnt++; $display("FAIL ferr_no_valid: got %0d want %0d", got_q.size(), base); end
    cmp_cnt++; if (data !== 8'h5A) begin mism_cnt++; $display("FAIL ferr_data_kept: got %h want 5a", data); end
    cmp_cnt++; if (busy !== 1'b1) begin mism_cnt++; $display("FAIL ferr_busy_break: got %b want 1", busy); end
    rx_line = 1'b1;
    repeat (10) @(negedge clock);
    cmp_cnt++; if (busy !== 1'b0) begin mism_cnt++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
    send_frame(8'h42, 1'b1, C, 1'b0);
    repeat (5) @(negedge clock);
    cmp_cnt++; if (data !== 8'h42) begin mism_cnt++; $display("FAIL ferr_next_data: got %h want 42", data); end
    cmp_cnt++; if (ferr_cnt !== 1) begin mism_cnt++; $display("FAIL ferr_next_no_ferr: got %0d want 1", ferr_cnt); end
  endtask

  task automatic test_reset_midframe;
    int base;
    int fbase;
    base = got_q.size();
    fbase = ferr_cnt;
    fork
      send_frame(8'hC3, 1'b1, C, 1'b0);
      begin
        repeat (5 * C + 100) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cmp_cnt++; if (data !== 8'h00) begin mism_cnt++; $display("FAIL midrst_data: got %h want 00", data); end
        cmp_cnt++; if (busy !== 1'b0) begin mism_cnt++; $display("FAIL midrst_busy: got %b want 0", busy); end
        cmp_cnt++; if (valid !== 1'b0 || frame_error !== 1'b0) begin mism_cnt++; $display("FAIL midrst_pulses: got %b%b want 00", valid, frame_error); end
      end
    join
    repeat (300) @(negedge clock);
    cmp_cnt++; if (got_q.size() !== base) begin mism_cnt++; $display("FAIL midrst_no_valid: got %0d want %0d", got_q.size(), base); end
    cmp_cnt++; if (ferr_cnt !== fbase) begin mism_cnt++; $display("FAIL midrst_no_ferr: got %0d want %0d", ferr_cnt, fbase); end
    cmp_cnt++; if (busy !== 1'b0) begin mism_cnt++; $display("FAIL midrst_idle: got %b want 0", busy); end
    send_frame(8'h7E, 1'b1, C, 1'b0);
    repeat (5) @(negedge clock);
    cmp_cnt++; if (got_q.size() !== base + 1) begin mism_cnt++; $display("FAIL midrst_next_count: got %0d want %0d", got_q.size(), base + 1); end
    cmp_cnt++; if (data !== 8'h7E) begin mism_cnt++; $display("FAIL midrst_next_data: got %h want 7e", data); end
  endtask

  task automatic test_loopback;
    logic [7:0] b;
    lb_q.delete();
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, LB_C, 1'b1);
    end
    repeat (10) @(negedge clock);
    cmp_cnt++; if (lb_q.size() !== 256) begin mism_cnt++; $display("FAIL loop_count: got %0d want 256", lb_q.size()); end
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      cmp_cnt++; if (lb_q[i] !== b) begin mism_cnt++; $display("FAIL loop_data%0d: got %h want %h", i, lb_q[i], b); end
    end
    cmp_cnt++; if (lb_ferr_cnt !== 0) begin mism_cnt++; $display("FAIL loop_ferr: got %0d want 0", lb_ferr_cnt); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_loopback();
    cmp_cnt++; if (overlap_cnt !== 0) begin mism_cnt++; $display("FAIL pulse_overlap: got %0d want 0", overlap_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
    $finish;
  end

endmodule
